// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state encoding and constants for the memory block-copy master
package mem_copy_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-by-word block copy on the shared memory port; MEM_COPY_FILL_EN adds constant-fill mode
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int LEN_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
`ifdef MEM_COPY_FILL_EN
  input  logic                  fill_mode,
  input  logic [31:0]           fill_value,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [31:0]           Write_data,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [31:0]           Mem_data
);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
  logic [LEN_WIDTH-1:0] count;
  logic [31:0] buffer, fill_word;
  logic err_flag, fill, fill_req, misaligned, last;
`ifdef MEM_COPY_FILL_EN
  assign fill_req  = fill_mode;
  assign fill_word = fill_value;
`else
  assign fill_req  = 1'b0;
  assign fill_word = 32'h0;
`endif
  // source alignment is irrelevant when no reads are issued
  assign misaligned = |(dst_addr[1:0] & ALIGN_MASK) || (!fill_req && |(src_addr[1:0] & ALIGN_MASK));
  assign last = count == LEN_WIDTH'(1);
  always_comb begin
    state_nxt = state == IDLE  ? (!start ? IDLE : (misaligned || len_words == '0) ? FIN : fill_req ? WRITE : READ) :
                state == READ  ? WRITE :
                state == WRITE ? (last ? FIN : fill ? WRITE : READ) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      buffer   <= '0;
      err_flag <= 1'b0;
      fill     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          err_flag <= misaligned;
          src_ptr  <= src_addr;
          dst_ptr  <= dst_addr;
          count    <= len_words;
          fill     <= fill_req;
          if (fill_req) buffer <= fill_word;
        end
        READ: begin
          buffer  <= Mem_data;
          src_ptr <= src_ptr + ADDR_WIDTH'(WORD_BYTES);
        end
        WRITE: begin
          dst_ptr <= dst_ptr + ADDR_WIDTH'(WORD_BYTES);
          count   <= count - LEN_WIDTH'(1);
        end
        FIN: err_flag <= 1'b0;
        default: ;
      endcase
    end
  end
  assign busy       = state != IDLE;
  assign done       = state == FIN;
  assign err        = done && err_flag;
  assign MemRead    = state == READ;
  assign MemWrite   = state == WRITE;
  assign Address    = MemRead ? src_ptr : MemWrite ? dst_ptr : '0;
  assign Write_data = MemWrite ? buffer : 32'h0;
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: directed and random copies checked against a sequential word-copy reference model
module tb_mem_copy_master;
  logic clk = 1'b0, reset, start;
  logic [31:0] src_addr, dst_addr, Address, Write_data, Mem_data;
  logic [7:0] len_words;
  logic busy, done, err, MemRead, MemWrite;
`ifdef MEM_COPY_FILL_EN
  logic fill_mode;
  logic [31:0] fill_value;
`endif
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int n_chk = 0, n_err = 0;

  mem_copy_master #(.LEN_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words),
`ifdef MEM_COPY_FILL_EN
    .fill_mode(fill_mode), .fill_value(fill_value),
`endif
    .busy(busy), .done(done), .err(err), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data)
  );

  always #5 clk = ~clk;
  assign Mem_data = mem[Address[11:2]];
  always @(posedge clk) if (MemWrite) mem[Address[11:2]] <= Write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int mm = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk(tag, mm, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"}, {busy, done, err, MemRead, MemWrite}, 0);
    chk({tag, "_addr"}, Address, 0);
    chk({tag, "_wdata"}, Write_data, 0);
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input bit fill,
                     input logic [31:0] fv, input bit noise);
    logic [31:0] exp_wd [$];
    int rd = 0, wr = 0, cyc = 1, done_cyc = -1;
    bit both = 0, busy_gap = 0, e = 0;
    bit bad = (d[1:0] != 0) || (!fill && s[1:0] != 0);
    int exp_done = (bad || n == 0) ? 1 : fill ? n + 1 : 2 * n + 1;
    if (!bad) for (int i = 0; i < n; i++) begin
      logic [31:0] v = fill ? fv : ref_mem[((s >> 2) + i) & 1023];
      exp_wd.push_back(v);
      ref_mem[((d >> 2) + i) & 1023] = v;
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = 8'(n); start = 1'b1;
`ifdef MEM_COPY_FILL_EN
    fill_mode = fill; fill_value = fv;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc <= 600) begin
      if (MemRead) begin
        chk("rd_addr", Address, s + 32'(4 * rd));
        rd++;
      end
      if (MemWrite) begin
        chk("wr_addr", Address, d + 32'(4 * wr));
        chk("wr_data", Write_data, wr < exp_wd.size() ? exp_wd[wr] : 32'hx);
        wr++;
      end
      if (MemRead && MemWrite) both = 1;
      if (!busy) busy_gap = 1;
      if (noise && cyc == 3) begin
        start = 1'b1; src_addr = 32'h3C0; dst_addr = 32'h10; len_words = 8'd7;
      end
      if (noise && cyc == 5) start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        e = err;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_cyc", done_cyc, exp_done);
    chk("err", e, bad);
    chk("rd_cnt", rd, (bad || fill) ? 0 : n);
    chk("wr_cnt", wr, bad ? 0 : n);
    chk("rd_wr_both", both, 0);
    chk("busy_during", busy_gap, 0);
    @(posedge clk); #1;
    chk_quiet("after_done");
    chk_mem("mem");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
`ifdef MEM_COPY_FILL_EN
    fill_mode = 1'b0; fill_value = '0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[32'h20 + i] = 32'hA0 + 32'(i);
    ref_mem = mem;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk) reset = 1'b0;

    run(32'h80, 32'h100, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("dir_word", mem[32'h40 + i], 32'hA0 + 32'(i));
    run(32'h80, 32'h100, 0, 0, 0, 0);
    run(32'h82, 32'h100, 3, 0, 0, 0);
    run(32'h80, 32'h101, 2, 0, 0, 0);
    run(32'h40, 32'h200, 5, 0, 0, 1);
    run(32'h180, 32'h184, 6, 0, 0, 0);
    run(32'h300, 32'h300, 3, 0, 0, 0);

    // abort: reset sampled at the end of the second READ, so only word 0 lands
    @(negedge clk);
    src_addr = 32'h80; dst_addr = 32'h300; len_words = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_rd", MemRead, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_quiet("abort");
    reset = 1'b0;
    ref_mem[32'h300 >> 2] = ref_mem[32'h20];
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("abort_idle");
    chk_mem("abort_mem");
    run(32'h84, 32'h380, 3, 0, 0, 0);

`ifdef MEM_COPY_FILL_EN
    run(32'h3, 32'hFFFFFFF8, 3, 1, 32'hDEADBEEF, 0);
    run(32'h0, 32'h200, 5, 1, $urandom, 0);
`endif

    for (int k = 0; k < 20; k++) begin
      logic [31:0] s = 32'($urandom_range(0, 1023)) << 2;
      logic [31:0] d = 32'($urandom_range(0, 1023)) << 2;
      int n = (k == 7) ? 255 : $urandom_range(0, 12);
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
`ifdef MEM_COPY_FILL_EN
      run(s, d, n, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0);
`else
      run(s, d, n, 0, 0, $urandom_range(0, 3) == 0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
